// File: rtl/draw_pkg.sv
// Shared FSM state, pixel packing constants and
// byte-enable helper for the pixel writer.
package draw_pkg;

   localparam int PIX_PER_WORD = 4;
   localparam int COLOUR_W     = 8;
   localparam int INDEX_W      = 19;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CALC  = 2'd1,
      S_WRITE = 2'd2,
      S_ACK   = 2'd3
   } state_t;

   function automatic logic [PIX_PER_WORD-1:0] be_onehot(
      input logic [1:0] i_lane
   );
      logic [PIX_PER_WORD-1:0] w_be;
      w_be = '0;
      w_be[i_lane] = 1'b1;
      return w_be;
   endfunction

endpackage

// File: rtl/pixel_addr_calc.sv
// Registered linear pixel index: y*SCREEN_W + x,
// one cycle latency, 19-bit unsigned wrap.
module pixel_addr_calc
   import draw_pkg::*;
#(
   parameter int SCREEN_W = 640
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [9:0]         i_x,
   input  logic [8:0]         i_y,
   output logic [INDEX_W-1:0] o_index
);

   localparam logic [INDEX_W-1:0] W_IDX = INDEX_W'(SCREEN_W);

   logic [INDEX_W-1:0] r_index;

   // index recomputed every cycle from the latched coordinates
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_index <= '0;
      end else begin
         r_index <= INDEX_W'(i_y) * W_IDX + INDEX_W'(i_x);
      end
   end

   assign o_index = r_index;

endmodule

// File: rtl/pixel_writer.sv
// Four-phase draw request to 32-bit frame-buffer write.
// Optional macro PIXEL_WRITER_CLIP_EN drops off-screen pixels.
module pixel_writer
   import draw_pkg::*;
#(
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480,
   parameter int ADDR_W   = 17
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                de_req,
   output logic                de_ack,
   input  logic [9:0]          de_x,
   input  logic [8:0]          de_y,
   input  logic [COLOUR_W-1:0] de_colour,
   output logic                busy,
   output logic                mem_req,
   input  logic                mem_ack,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [31:0]         mem_wdata,
   output logic [3:0]          mem_be,
   output logic [19:0]         pixel_count
);

   state_t r_state;
   state_t w_next;

   logic [9:0]          r_x;
   logic [8:0]          r_y;
   logic [COLOUR_W-1:0] r_col;
   logic                r_de_ack;
   logic [19:0]         r_pix_cnt;
   logic [INDEX_W-1:0]  w_index;
   logic                w_wr;
   logic                w_done;
   logic                w_skip;

   pixel_addr_calc #(
      .SCREEN_W (SCREEN_W)
   ) u_calc (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_x     (r_x),
      .i_y     (r_y),
      .o_index (w_index)
   );

`ifdef PIXEL_WRITER_CLIP_EN
   assign w_skip = (32'(r_x) >= SCREEN_W) ||
                   (32'(r_y) >= SCREEN_H);
`else
   logic w_unused_h;
   assign w_unused_h = (SCREEN_H != 0);
   assign w_skip     = 1'b0;
`endif

   assign w_wr   = (r_state == S_WRITE);
   assign w_done = w_wr && mem_ack;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // next-state decode
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (de_req) w_next = S_CALC;
         S_CALC:  w_next = w_skip ? S_ACK : S_WRITE;
         S_WRITE: if (mem_ack) w_next = S_ACK;
         S_ACK:   if (r_de_ack && !de_req) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // capture request fields only when accepted in IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x   <= '0;
         r_y   <= '0;
         r_col <= '0;
      end else if (r_state == S_IDLE && de_req) begin
         r_x   <= de_x;
         r_y   <= de_y;
         r_col <= de_colour;
      end
   end

   // ack rises on first ACK cycle, falls once de_req seen low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_de_ack <= 1'b0;
      end else if (r_state == S_ACK) begin
         if (!r_de_ack) begin
            r_de_ack <= 1'b1;
         end else if (!de_req) begin
            r_de_ack <= 1'b0;
         end
      end else begin
         r_de_ack <= 1'b0;
      end
   end

   // saturating count of completed memory writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pix_cnt <= '0;
      end else if (w_done && r_pix_cnt != 20'hFFFFF) begin
         r_pix_cnt <= r_pix_cnt + 20'd1;
      end
   end

   assign de_ack      = r_de_ack;
   assign busy        = (r_state != S_IDLE);
   assign pixel_count = r_pix_cnt;
   assign mem_req     = w_wr;
   assign mem_addr    = w_wr ?
                        ADDR_W'(w_index[INDEX_W-1:2]) : '0;
   assign mem_be      = w_wr ? be_onehot(w_index[1:0]) : '0;
   assign mem_wdata   = w_wr ? {PIX_PER_WORD{r_col}} : '0;

endmodule

// File: tb/tb_pixel_writer.sv
// Randomised bench for pixel_writer against a
// coordinate-level reference model.
module tb_pixel_writer;

   logic        clk;
   logic        rst_n;
   logic        de_req;
   logic        de_ack;
   logic [9:0]  de_x;
   logic [8:0]  de_y;
   logic [7:0]  de_colour;
   logic        busy;
   logic        mem_req;
   logic        mem_ack;
   logic [16:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [19:0] pixel_count;

   int          n_checks;
   int          n_errors;
   logic [19:0] m_cnt;

   pixel_writer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .de_req      (de_req),
      .de_ack      (de_ack),
      .de_x        (de_x),
      .de_y        (de_y),
      .de_colour   (de_colour),
      .busy        (busy),
      .mem_req     (mem_req),
      .mem_ack     (mem_ack),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_be      (mem_be),
      .pixel_count (pixel_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ack"},   32'(de_ack), 0);
      check({tag, "_busy"},  32'(busy), 0);
      check({tag, "_req"},   32'(mem_req), 0);
      check({tag, "_addr"},  32'(mem_addr), 0);
      check({tag, "_wdata"}, mem_wdata, 0);
      check({tag, "_be"},    32'(mem_be), 0);
      check({tag, "_cnt"},   32'(pixel_count), 0);
   endtask

   // one full draw: d = mem_ack delay, hold = extra
   // cycles de_req stays high after de_ack
   task automatic pw_write(input logic [9:0] x,
                           input logic [8:0] y,
                           input logic [7:0] c,
                           input int d,
                           input int hold);
      bit          clip;
      int          lat;
      int          lin;
      logic [18:0] idx;
      logic [31:0] e_addr;
      logic [31:0] e_be;
      clip = 1'b0;
`ifdef PIXEL_WRITER_CLIP_EN
      clip = (x >= 640) || (y >= 480);
`endif
      lin    = int'(y) * 640 + int'(x);
      idx    = lin[18:0];
      e_addr = 32'(idx >> 2);
      e_be   = 32'(1) << idx[1:0];
      @(posedge clk); #1;
      de_x = x; de_y = y; de_colour = c; de_req = 1'b1;
      lat = 0;
      for (int n = 0; n < 20 && !mem_req && !de_ack; n++) begin
         @(posedge clk); #1;
         lat++;
      end
      if (clip) begin
         check("clip_noreq", 32'(mem_req), 0);
         check("clip_lat", lat, 3);
      end else begin
         check("req", 32'(mem_req), 1);
         check("addr", 32'(mem_addr), e_addr);
         check("be", 32'(mem_be), e_be);
         check("wdata", mem_wdata, {4{c}});
         de_x = ~x; de_y = ~y; de_colour = ~c;
         for (int k = 0; k < d; k++) begin
            @(posedge clk); #1;
            lat++;
            check("hold_req", 32'(mem_req), 1);
            check("hold_addr", 32'(mem_addr), e_addr);
            check("hold_wdata", mem_wdata, {4{c}});
            check("early_ack", 32'(de_ack), 0);
         end
         mem_ack = 1'b1;
         @(posedge clk); #1;
         lat++;
         mem_ack = 1'b0;
         check("req_fall", 32'(mem_req), 0);
         if (m_cnt != 20'hFFFFF) m_cnt = m_cnt + 20'd1;
         for (int n = 0; n < 20 && !de_ack; n++) begin
            @(posedge clk); #1;
            lat++;
         end
         check("lat", lat, 4 + d);
      end
      check("ack", 32'(de_ack), 1);
      check("cnt", 32'(pixel_count), 32'(m_cnt));
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         check("no_rereq", 32'(mem_req), 0);
         check("ack_held", 32'(de_ack), 1);
      end
      de_req = 1'b0;
      for (int n = 0; n < 20 && de_ack; n++) begin
         @(posedge clk); #1;
      end
      check("ack_drop", 32'(de_ack), 0);
      check("idle", 32'(busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int acks;
      n_checks = 0;
      n_errors = 0;
      m_cnt    = '0;
      rst_n = 1'b0; de_req = 1'b0; mem_ack = 1'b0;
      de_x = '0; de_y = '0; de_colour = '0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("rst");
      @(negedge clk); rst_n = 1'b1;

      pw_write(10'd5, 9'd2, 8'hA5, 0, 0);
      pw_write(10'd17, 9'd33, 8'h3C, 10, 0);
      pw_write(10'd1, 9'd0, 8'h77, 1, 5);
      pw_write(10'd700, 9'd0, 8'h11, 0, 0);
      pw_write(10'd639, 9'd479, 8'hFE, 2, 0);

      // de_req already low when ACK is entered
      @(posedge clk); #1;
      de_x = 10'd3; de_y = 9'd1; de_colour = 8'h42; de_req = 1'b1;
      @(posedge clk); #1;
      de_req = 1'b0;
      for (int n = 0; n < 10 && !mem_req; n++) begin
         @(posedge clk); #1;
      end
      check("short_req", 32'(mem_req), 1);
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (m_cnt != 20'hFFFFF) m_cnt = m_cnt + 20'd1;
      acks = 0;
      for (int n = 0; n < 6; n++) begin
         @(posedge clk); #1;
         if (de_ack) acks++;
      end
      check("short_ack_len", acks, 1);
      check("short_cnt", 32'(pixel_count), 32'(m_cnt));

      // random traffic
      for (int i = 0; i < 25; i++) begin
         logic [9:0] rx;
         logic [8:0] ry;
         rx = 10'($urandom_range(0, 1023));
         ry = 9'($urandom_range(0, 511));
         if ($urandom_range(0, 3) != 0) begin
            rx = 10'($urandom_range(0, 639));
            ry = 9'($urandom_range(0, 479));
         end
         pw_write(rx, ry, 8'($urandom), $urandom_range(0, 3),
                  $urandom_range(0, 2));
      end

      // reset pulse in the middle of WRITE
      @(posedge clk); #1;
      de_x = 10'd10; de_y = 9'd3; de_colour = 8'h5A; de_req = 1'b1;
      for (int n = 0; n < 10 && !mem_req; n++) begin
         @(posedge clk); #1;
      end
      check("mid_req", 32'(mem_req), 1);
      #1 rst_n = 1'b0;
      #1;
      check_all_zero("async");
      de_req = 1'b0;
      m_cnt  = '0;
      @(negedge clk); rst_n = 1'b1;
      pw_write(10'd8, 9'd4, 8'hC3, 0, 0);

      // saturation
      @(negedge clk);
      force dut.r_pix_cnt = 20'hFFFFE;
      #1;
      release dut.r_pix_cnt;
      m_cnt = 20'hFFFFE;
      for (int i = 0; i < 3; i++) begin
         pw_write(10'($urandom_range(0, 639)),
                  9'($urandom_range(0, 479)),
                  8'($urandom), 0, 0);
      end
      check("sat", 32'(pixel_count), 32'h000FFFFF);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pixel_writer.md
PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640, meaning pixels per row.
REQ-002 SHALL have parameter SCREEN_H, default 480, meaning rows per frame.
REQ-003 SHALL have parameter ADDR_W, default 17, meaning frame-buffer word-address width (32-bit words, 4 pixels per word).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-006 SHALL have port de_req, input, 1, meaning the draw request from the initiator (edge detector), four-phase.
REQ-007 SHALL have port de_ack, output, 1, meaning the draw acknowledge to the initiator.
REQ-008 SHALL have ports de_x input 10, de_y input 9, de_colour input 8, meaning the pixel column, row and 8bpp colour, valid while de_req is high.
REQ-009 SHALL have port busy, output, 1, meaning high in every state other than IDLE.
REQ-010 SHALL have ports mem_req output 1, mem_ack input 1, mem_addr output ADDR_W, mem_wdata output 32, mem_be output 4, meaning the frame-buffer write port.
REQ-011 SHALL have port pixel_count, output, 20, meaning the number of pixels written since reset.

Function
REQ-012 SHALL implement the FSM IDLE -> CALC -> WRITE -> ACK -> IDLE.
REQ-013 In IDLE, de_req sampled high SHALL latch de_x, de_y and de_colour and move to CALC.
REQ-014 CALC SHALL compute, in one registered cycle, index = de_y*SCREEN_W + de_x in 19 bits unsigned, then move to WRITE.
REQ-015 WRITE SHALL drive mem_req=1, mem_addr=index[18:2] truncated to ADDR_W, mem_be = one-hot bit index[1:0], and mem_wdata = colour replicated four times.
REQ-016 Address and data outputs SHALL be held stable while mem_req is high.
REQ-017 mem_req SHALL fall on the cycle after mem_ack is sampled high; pixel_count SHALL then increment and the FSM SHALL move to ACK.
REQ-018 ACK SHALL drive de_ack=1 until de_req is sampled low, then drop de_ack and return to IDLE.
REQ-019 Minimum latency from de_req rising to de_ack rising SHALL be 4 cycles when mem_ack is high on the first WRITE cycle.
REQ-020 If de_req is already low on entry to ACK, de_ack SHALL be high for exactly one cycle.
REQ-021 A de_req that stays high after de_ack falls SHALL NOT start a new write until de_req has been low for at least one cycle.
REQ-022 pixel_count SHALL saturate at 20'hFFFFF and not wrap.
REQ-023 Input changes outside IDLE SHALL be ignored.

Reset
REQ-024 While rst_n is low, the block SHALL force state=IDLE and drive de_ack=0, busy=0, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, and pixel_count=0.
REQ-025 Reset asserted mid-WRITE SHALL abandon the write with no retry, and the next request after reset SHALL be handled normally.

Configuration
REQ-026 Macro PIXEL_WRITER_CLIP_EN defined SHALL make CALC check de_x>=SCREEN_W or de_y>=SCREEN_H; an out-of-range pixel SHALL skip WRITE, go straight to ACK, and not increment pixel_count.
REQ-027 Without PIXEL_WRITER_CLIP_EN, no range check SHALL exist and out-of-range coordinates SHALL be written at the truncated address.

Structure
REQ-028 The FSM state enum, the pixels-per-word constant (4) and the colour width (8) SHALL live in shared package draw_pkg.
REQ-029 Address arithmetic SHALL be isolated in sub-module pixel_addr_calc, which is registered and has one-cycle latency.

Verification
REQ-030 Bench SHALL drive (x=5, y=2, colour=8'hA5) with mem_ack immediately high -> mem_addr=321, mem_be=4'b0010, mem_wdata=32'hA5A5A5A5, de_ack 4 cycles after de_req, pixel_count=1.
REQ-031 Bench SHALL hold mem_ack low 10 cycles -> mem_req and address/data stable for 10 cycles, de_ack only after mem_ack.
REQ-032 Bench SHALL keep de_req high after de_ack -> no second mem_req until de_req is low then high.
REQ-033 Bench SHALL drive (x=700, y=0) with PIXEL_WRITER_CLIP_EN -> no mem_req, de_ack asserted, pixel_count unchanged; without the macro -> mem_addr=175, mem_be=4'b0001.
REQ-034 Bench SHALL pulse rst_n low while mem_req=1 -> all outputs 0 asynchronously, and the next request completes normally.
REQ-035 Bench SHALL preload pixel_count=20'hFFFFE via force, then issue 3 writes -> pixel_count=20'hFFFFF.
